prng_check: RTL and testbench
=============================

# prng_check

Receive-side companion to the `prng` generator: regenerates the expected 32-bit pseudo-random word stream locally and compares it beat-by-beat against an incoming stream. It sits at the far end of a link or loopback path, for example DSP/fabric data-path BIST or transceiver loopback, and reports lock, loss of lock and error statistics. It uses the same two-LFSR signed-product construction as the generator, built on the codebase `lfsr` next-state module, so it tracks the generator word-for-word.

## Interface
- `W0`, 18, width of LFSR 0 (signed multiplicand).
- `W1`, 25, width of LFSR 1 (signed multiplier).
- `SEED0`, 1, LFSR 0 initial state; must be nonzero.
- `SEED1`, 1, LFSR 1 initial state; must be nonzero.
- `LOCK_COUNT`, 8, consecutive matches required to declare lock (1..255).
- `LOSS_COUNT`, 4, consecutive mismatches in LOCKED that cause loss of lock (1..255).

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `restart` in 1: synchronous pulse; reloads seeds and returns to ACQUIRE.
- `din` in 32: received word.
- `din_valid` in 1: `din` is a valid beat this cycle.
- `state` out 2: ACQUIRE=0, LOCKED=1, LOST=2.
- `locked` out 1: high while `state`==LOCKED.
- `lost` out 1: high while `state`==LOST (sticky).
- `mismatch` out 1: one-cycle pulse per mismatching beat in LOCKED.
- `err_count` out 32: mismatches counted in LOCKED, saturating.
- `word_count` out 32: valid beats compared in LOCKED, saturating.

## Operation
- Local generator holds `s0`[W0], `s1`[W1]. Expected word `exp` = low 32 bits of the (W0+W1)-bit signed product `$signed(s0)*$signed(s1)`. Advancing the generator sets `s0`=lfsr(`s0`) and `s1`=lfsr(`s1`). With default seeds, the first expected word is 0x00000001.
- The generator advances only on a valid beat that it accepts as aligned (see below). Cycles with `din_valid`=0 change nothing.
- ACQUIRE:
  - Generator starts at the seeds. `match_cnt`=0.
  - If a valid beat has `din`==`exp` and `match_cnt`==0: advance the generator, and set `match_cnt`=1. This is how leading junk, such as the generator's post-reset 0 word, gets skipped.
  - If a valid beat has `din`==`exp` and `match_cnt`>0: advance the generator and increment `match_cnt`. When `match_cnt` reaches `LOCK_COUNT`, go to LOCKED and clear `miss_cnt`.
  - If a valid beat has `din`!=`exp`: if `match_cnt`==0, hold the generator and wait. If `match_cnt`>0, reload the seeds and set `match_cnt`=0. That beat is not re-compared against the seed word.
- LOCKED: every valid beat advances the generator, whether or not it matches.
  - Match: `miss_cnt`=0 and `word_count`+1.
  - Mismatch: pulse `mismatch`, `err_count`+1, `word_count`+1, `miss_cnt`+1.
  - When `miss_cnt` reaches `LOSS_COUNT`, go to LOST.
- LOST: the generator is frozen and `din` is ignored. Only `restart` or `rst` leaves this state.
- `restart`: from any state, reload the seeds and go to ACQUIRE with `match_cnt`=`miss_cnt`=0. Counters are cleared. A beat valid in the same cycle is discarded, because `restart` wins over `din_valid`.
- Counters saturate at 0xFFFFFFFF and never wrap.

## Timing
- All outputs are registered. A beat sampled at edge N is reflected in `state`, `locked`, `lost`, `mismatch` and the counters after edge N.
  - `locked` rises in the cycle after the LOCK_COUNT-th matching beat.
  - `mismatch` is high for exactly one cycle per bad beat. Back-to-back bad beats give back-to-back pulses.
  - The LOSS_COUNT-th consecutive mismatch pulses `mismatch` and enters LOST on the same edge.
- Reset values: `state`=ACQUIRE, `locked`=0, `lost`=0, `mismatch`=0, `err_count`=0, `word_count`=0, generator at the seeds.
- Reset asserted mid-operation forces all reset values immediately (asynchronous). Release is synchronous to `clk`.
- The multiply/compare path is single-cycle, combinational from `s0`/`s1`; `exp` is available every cycle.

## Configuration
- `PRNG_CHECK_STATS_EN` defined: `err_count` and `word_count` are implemented as specified.
- Not defined: both counters are tied to 0 and their registers are not built. State, `locked`, `lost` and `mismatch` behaviour is unchanged.

## Test plan
- Drive from `prng` via a loopback, with a first valid word of 0x00000000 followed by the generator stream -> the 0 is skipped, `locked`=1 after the 9th valid beat, and `err_count`=0 after 1000 beats.
- In LOCKED, flip `din`[0] on one beat -> one `mismatch` pulse, `err_count`=1, `locked` stays 1, and the next clean beat matches.
- In LOCKED, corrupt 4 consecutive beats -> 4 pulses, `state`=LOST, `lost`=1, `locked`=0, `err_count`=4. Further beats leave the counters unchanged.
- Partial acquire: 3 good beats, then 1 bad beat, then restart the generator stream -> the bad beat reloads the seeds, and lock is reached 8 beats after the stream restart.
- Random `din_valid` gaps (30% idle) while locked -> no mismatches, and `word_count` equals the number of valid beats.
- Assert `rst` while in LOCKED, then pulse `restart` while in LOST -> all outputs return to reset values, and a clean stream relocks after 8 beats.

Source files
------------

// File: rtl/prng_check.sv
// Receive-side PRNG checker: regenerates the two-LFSR signed-product word stream, acquires lock and tracks errors.
// Optional statistics counters are built only when PRNG_CHECK_STATS_EN is defined.

// Fibonacci LFSR next-state: shift left, feedback is the XOR of a maximal-length two-tap polynomial.
module prng_check_lfsr #(
  parameter int unsigned W = 18
) (
  input  logic [W-1:0] i_state,
  output logic [W-1:0] o_next
);

  function automatic int unsigned second_tap(input int unsigned w);
    case (w)
      3:       return 2;
      4:       return 3;
      5:       return 3;
      6:       return 5;
      7:       return 6;
      9:       return 5;
      10:      return 7;
      11:      return 9;
      15:      return 14;
      17:      return 14;
      18:      return 11;
      20:      return 17;
      21:      return 19;
      22:      return 21;
      23:      return 18;
      25:      return 22;
      28:      return 25;
      29:      return 27;
      31:      return 28;
      33:      return 20;
      35:      return 33;
      36:      return 25;
      39:      return 35;
      default: return w - 1;
    endcase
  endfunction

  localparam int unsigned T2 = second_tap(W);
  localparam logic [W-1:0] TAPS = (W'(1) << (W - 1)) | (W'(1) << (T2 - 1));

  assign o_next = {i_state[W-2:0], ^(i_state & TAPS)};

endmodule

module prng_check #(
  parameter int unsigned   W0         = 18,
  parameter int unsigned   W1         = 25,
  parameter logic [W0-1:0] SEED0      = W0'(1),
  parameter logic [W1-1:0] SEED1      = W1'(1),
  parameter int unsigned   LOCK_COUNT = 8,
  parameter int unsigned   LOSS_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic [1:0]  state,
  output logic        locked,
  output logic        lost,
  output logic        mismatch,
  output logic [31:0] err_count,
  output logic [31:0] word_count
);

  localparam int unsigned PW = W0 + W1;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_LOST    = 2'd2
  } state_t;

  state_t          r_state;
  logic [W0-1:0]   r_s0;
  logic [W1-1:0]   r_s1;
  logic [CW-1:0]   r_match_cnt;
  logic [CW-1:0]   r_miss_cnt;
  logic            r_locked;
  logic            r_lost;
  logic            r_mismatch;

  logic [W0-1:0]   w_s0_next;
  logic [W1-1:0]   w_s1_next;
  logic [31:0]     w_exp;
  logic            w_hit;

  prng_check_lfsr #(.W(W0)) u_lfsr0 (.i_state(r_s0), .o_next(w_s0_next));
  prng_check_lfsr #(.W(W1)) u_lfsr1 (.i_state(r_s1), .o_next(w_s1_next));

  // Expected word: low 32 bits of the full-width signed product.
  assign w_exp = 32'(PW'($signed(r_s0)) * PW'($signed(r_s1)));
  assign w_hit = (din == w_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACQUIRE;
      r_s0        <= SEED0;
      r_s1        <= SEED1;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_lost      <= 1'b0;
      r_mismatch  <= 1'b0;
    end else if (restart) begin
      r_state     <= ST_ACQUIRE;
      r_s0        <= SEED0;
      r_s1        <= SEED1;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_lost      <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      case (r_state)
        ST_ACQUIRE: begin
          if (din_valid) begin
            if (w_hit) begin
              r_s0 <= w_s0_next;
              r_s1 <= w_s1_next;
              if (r_match_cnt == CW'(LOCK_COUNT - 1)) begin
                r_state     <= ST_LOCKED;
                r_locked    <= 1'b1;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + CW'(1);
              end
            end else if (r_match_cnt != '0) begin
              // Partial run broken: restart the search from the seed word.
              r_s0        <= SEED0;
              r_s1        <= SEED1;
              r_match_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (din_valid) begin
            r_s0 <= w_s0_next;
            r_s1 <= w_s1_next;
            if (w_hit) begin
              r_miss_cnt <= '0;
            end else begin
              r_mismatch <= 1'b1;
              if (r_miss_cnt == CW'(LOSS_COUNT - 1)) begin
                r_state  <= ST_LOST;
                r_locked <= 1'b0;
                r_lost   <= 1'b1;
              end else begin
                r_miss_cnt <= r_miss_cnt + CW'(1);
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state    = r_state;
  assign locked   = r_locked;
  assign lost     = r_lost;
  assign mismatch = r_mismatch;

`ifdef PRNG_CHECK_STATS_EN
  logic [31:0] r_err_count;
  logic [31:0] r_word_count;
  logic        w_cnt_word;
  logic        w_cnt_err;

  assign w_cnt_word = !restart && din_valid && (r_state == ST_LOCKED);
  assign w_cnt_err  = w_cnt_word && !w_hit;

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count  <= '0;
      r_word_count <= '0;
    end else if (restart) begin
      r_err_count  <= '0;
      r_word_count <= '0;
    end else begin
      if (w_cnt_word && (r_word_count != '1)) r_word_count <= r_word_count + 32'd1;
      if (w_cnt_err && (r_err_count != '1))   r_err_count  <= r_err_count + 32'd1;
    end
  end

  assign err_count  = r_err_count;
  assign word_count = r_word_count;
`else
  assign err_count  = '0;
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_prng_check.sv
// Directed self-checking bench for prng_check with an independent loopback generator model.
module tb_prng_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic [31:0] din;
  logic        din_valid;
  logic [1:0]  state;
  logic        locked;
  logic        lost;
  logic        mismatch;
  logic [31:0] err_count;
  logic [31:0] word_count;

  always #5 clk = ~clk;

  prng_check dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .din        (din),
    .din_valid  (din_valid),
    .state      (state),
    .locked     (locked),
    .lost       (lost),
    .mismatch   (mismatch),
    .err_count  (err_count),
    .word_count (word_count)
  );

`ifdef PRNG_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int exp_err  = 0;
  int exp_word = 0;

  logic [17:0] g0;
  logic [24:0] g1;

  function automatic logic [17:0] m_l0(input logic [17:0] s);
    return {s[16:0], s[17] ^ s[10]};
  endfunction

  function automatic logic [24:0] m_l1(input logic [24:0] s);
    return {s[23:0], s[24] ^ s[21]};
  endfunction

  function automatic logic [31:0] m_word(input logic [17:0] a, input logic [24:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 32'(sa * sb);
  endfunction

  task automatic gen_reset();
    g0 = 18'd1;
    g1 = 25'd1;
  endtask

  task automatic gen_adv();
    g0 = m_l0(g0);
    g1 = m_l1(g1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_err"},  err_count,  STATS ? 32'(exp_err)  : 32'd0);
    chk({tag, "_word"}, word_count, STATS ? 32'(exp_word) : 32'd0);
  endtask

  // Hold inputs across one rising edge; return at the following falling edge.
  task automatic step(input logic v, input logic [31:0] d);
    din_valid = v;
    din       = d;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic send_good();
    step(1'b1, m_word(g0, g1));
    gen_adv();
  endtask

  initial begin
    logic [31:0] hv [8];
    int mm;
    int nvalid;
    hv = '{32'h1, 32'h4, 32'h10, 32'h40, 32'h100, 32'h400, 32'h1000, 32'h4000};

    rst = 1'b1; restart = 1'b0; din_valid = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_lost", 32'(lost), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk_cnt("rst");
    rst = 1'b0;
    @(negedge clk);

    // Leading 0 word is skipped, then 8 hand-computed words lock.
    step(1'b1, 32'h0);
    chk("skip0_state", 32'(state), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, hv[i]);
      if (i == 6) chk("lock_early", 32'(locked), 32'd0);
    end
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_state", 32'(state), 32'd1);
    gen_reset();
    repeat (8) gen_adv();

    // Long clean run.
    mm = 0;
    for (int i = 0; i < 200; i++) begin
      send_good();
      if (mismatch) mm++;
    end
    exp_word += 200;
    chk("clean_mismatches", 32'(mm), 32'd0);
    chk("clean_locked", 32'(locked), 32'd1);
    chk_cnt("clean");

    // Single bit flip.
    step(1'b1, m_word(g0, g1) ^ 32'h1);
    gen_adv();
    exp_err++; exp_word++;
    chk("flip_mismatch", 32'(mismatch), 32'd1);
    chk("flip_locked", 32'(locked), 32'd1);
    chk_cnt("flip");
    send_good();
    exp_word++;
    chk("flip_next_mismatch", 32'(mismatch), 32'd0);
    chk_cnt("flip_next");

    // Random idle gaps.
    mm = 0; nvalid = 0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        step(1'b0, $urandom);
      end else begin
        send_good();
        nvalid++;
      end
      if (mismatch) mm++;
    end
    exp_word += nvalid;
    chk("gaps_mismatches", 32'(mm), 32'd0);
    chk("gaps_locked", 32'(locked), 32'd1);
    chk_cnt("gaps");

    // Four consecutive bad beats lose lock.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, m_word(g0, g1) ^ 32'h8000_0000);
      gen_adv();
      exp_err++; exp_word++;
      chk("loss_pulse", 32'(mismatch), 32'd1);
      if (i < 3) chk("loss_still_locked", 32'(state), 32'd1);
    end
    chk("loss_state", 32'(state), 32'd2);
    chk("loss_lost", 32'(lost), 32'd1);
    chk("loss_locked", 32'(locked), 32'd0);
    chk_cnt("loss");
    for (int i = 0; i < 5; i++) step(1'b1, $urandom);
    chk("lost_frozen_mismatch", 32'(mismatch), 32'd0);
    chk("lost_frozen_state", 32'(state), 32'd2);
    chk_cnt("lost_frozen");

    // Restart wins over a valid beat carrying the seed word.
    restart = 1'b1;
    step(1'b1, 32'h1);
    restart = 1'b0;
    exp_err = 0; exp_word = 0;
    chk("restart_state", 32'(state), 32'd0);
    chk("restart_lost", 32'(lost), 32'd0);
    chk("restart_locked", 32'(locked), 32'd0);
    chk("restart_mismatch", 32'(mismatch), 32'd0);
    chk_cnt("restart");

    // Partial acquire broken by a bad beat, then stream restarts from seeds.
    gen_reset();
    repeat (3) send_good();
    step(1'b0, 32'h40);
    step(1'b1, 32'hDEAD_BEEF);
    chk("partial_state", 32'(state), 32'd0);
    gen_reset();
    for (int i = 0; i < 8; i++) begin
      send_good();
      if (i == 6) chk("partial_early", 32'(locked), 32'd0);
    end
    chk("partial_locked", 32'(locked), 32'd1);
    chk("partial_state_locked", 32'(state), 32'd1);

    // Async reset while locked with nonzero counters.
    step(1'b1, m_word(g0, g1) ^ 32'h10);
    gen_adv();
    exp_err = 1; exp_word = 1;
    chk_cnt("pre_rst");
    #2 rst = 1'b1;
    #1;
    exp_err = 0; exp_word = 0;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk_cnt("arst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    gen_reset();
    for (int i = 0; i < 8; i++) begin
      send_good();
      if (i == 6) chk("relock_early", 32'(locked), 32'd0);
    end
    chk("relock_locked", 32'(locked), 32'd1);
    send_good();
    exp_word++;
    chk("relock_mismatch", 32'(mismatch), 32'd0);
    chk_cnt("relock");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
